npu_cfg_uart_bridge: RTL and testbench

- Upstream front-end for ip5_riscv_npu_top: turns a byte stream from the chip-level UART receiver into single-beat transactions on the NPU config bus (cfg_addr/cfg_wr_en/cfg_rd_en/cfg_wdata/cfg_rdata).
- Returns acknowledgements and read data as bytes to the UART transmitter.
- Lets a host on the shared UART pad program and poll the NPU without a CPU.

---
 rtl/npu_cfg_uart_bridge.sv | 185 ++++++++++++++++++
 tb/tb_npu_cfg_uart_bridge.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_cfg_uart_bridge.sv
// npu_cfg_uart_bridge
//   Turns a byte stream from the chip UART receiver into single-beat
//   transactions on the NPU config bus. Responses (ACK, error, status or
//   four read-data bytes) go back out as bytes to the UART transmitter.
//
//   Frames (MSB first):
//     write : 57 ah al d3 d2 d1 d0  -> cfg_wr_en pulse, reply ACK_BYTE
//     read  : 52 ah al              -> cfg_rd_en pulse, reply d3 d2 d1 d0
//     status: 53                    -> reply {7'b0, halted}
//     other first byte or inter-byte idle of TIMEOUT cycles -> ERR_BYTE
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_data/valid/ready byte input stream (upstream stalls while rx_ready=0)
//   tx_data/valid/ready byte output stream
//   cfg_addr/wr_en/rd_en/wdata/rdata  NPU config bus
//   halted              NPU halted status, returned by the status frame
//   busy                a frame is in progress
//   err_count           saturating count of error frames
module npu_cfg_uart_bridge #(
  parameter int         RD_LAT   = 1,
  parameter int         TIMEOUT  = 100000,
  parameter logic [7:0] ACK_BYTE = 8'h4B,
  parameter logic [7:0] ERR_BYTE = 8'h45
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] cfg_addr,
  output logic        cfg_wr_en,
  output logic        cfg_rd_en,
  output logic [31:0] cfg_wdata,
  input  logic [31:0] cfg_rdata,
  input  logic        halted,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] OP_ST = 8'h53;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, EXEC, RDWAIT, RESP} state_t;

  state_t            state, state_next;
  logic              is_wr;
  logic [1:0]        byte_cnt;
  logic [15:0]       addr_sh;
  logic [31:0]       data_sh;
  logic [31:0]       resp_buf;   // outgoing bytes, current byte in [31:24]
  logic [2:0]        resp_left;
  logic [TO_W-1:0]   to_cnt;
  logic [2:0]        lat_cnt;
  logic              rx_fire, tx_fire, in_frame, timeout_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign rx_ready  = (state == IDLE) || (state == ADDR) || (state == DATA);
  assign tx_valid  = (state == RESP);
  assign tx_data   = resp_buf[31:24];
  assign busy      = (state != IDLE);
  assign cfg_wr_en = (state == EXEC) && is_wr;
  assign cfg_rd_en = (state == EXEC) && !is_wr;

  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign in_frame = (state == ADDR) || (state == DATA);
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = in_frame && !rx_fire && (to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (rx_fire) begin
        if ((rx_data == OP_WR) || (rx_data == OP_RD)) state_next = ADDR;
        else                                          state_next = RESP;
      end
      ADDR: begin
        if (rx_fire && (byte_cnt == 2'd1)) state_next = is_wr ? DATA : EXEC;
        else if (timeout_hit)              state_next = RESP;
      end
      DATA: begin
        if (rx_fire && (byte_cnt == 2'd3)) state_next = EXEC;
        else if (timeout_hit)              state_next = RESP;
      end
      EXEC:   state_next = is_wr ? RESP : RDWAIT;
      RDWAIT: if (lat_cnt == 3'(RD_LAT)) state_next = RESP;
      RESP:   if (tx_fire && (resp_left == 3'd1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      byte_cnt  <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
      cfg_addr  <= '0;
      cfg_wdata <= '0;
      resp_buf  <= '0;
      resp_left <= '0;
      to_cnt    <= '0;
      lat_cnt   <= '0;
      err_count <= '0;
    end else begin
      state <= state_next;

      if (rx_fire || !in_frame) to_cnt <= '0;
      else                      to_cnt <= to_cnt + 1'b1;

      case (state)
        IDLE: if (rx_fire) begin
          is_wr    <= (rx_data == OP_WR);
          byte_cnt <= '0;
          if (rx_data == OP_ST) begin
            resp_buf  <= {7'b0, halted, 24'h0};
            resp_left <= 3'd1;
          end else if ((rx_data != OP_WR) && (rx_data != OP_RD)) begin
            resp_buf  <= {ERR_BYTE, 24'h0};
            resp_left <= 3'd1;
            err_count <= sat_inc(err_count);
          end
        end
        ADDR: begin
          if (rx_fire) begin
            addr_sh  <= {addr_sh[7:0], rx_data};
            byte_cnt <= (byte_cnt == 2'd1) ? 2'd0 : byte_cnt + 2'd1;
            // Reads go straight to EXEC, so the bus address is loaded here.
            if ((byte_cnt == 2'd1) && !is_wr) cfg_addr <= {addr_sh[7:0], rx_data};
          end else if (timeout_hit) begin
            resp_buf  <= {ERR_BYTE, 24'h0};
            resp_left <= 3'd1;
            err_count <= sat_inc(err_count);
          end
        end
        DATA: begin
          if (rx_fire) begin
            data_sh  <= {data_sh[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              cfg_addr  <= addr_sh;
              cfg_wdata <= {data_sh[23:0], rx_data};
            end
          end else if (timeout_hit) begin
            resp_buf  <= {ERR_BYTE, 24'h0};
            resp_left <= 3'd1;
            err_count <= sat_inc(err_count);
          end
        end
        EXEC: begin
          if (is_wr) begin
            resp_buf  <= {ACK_BYTE, 24'h0};
            resp_left <= 3'd1;
          end
          lat_cnt <= 3'd1;
        end
        RDWAIT: begin
          // Capture on the RD_LAT-th RDWAIT cycle, when read data is valid.
          if (lat_cnt == 3'(RD_LAT)) begin
            resp_buf  <= cfg_rdata;
            resp_left <= 3'd4;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESP: if (tx_fire) begin
          resp_buf  <= {resp_buf[23:0], 8'h00};
          resp_left <= resp_left - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_cfg_uart_bridge.sv
// Testbench for npu_cfg_uart_bridge. Two instances (RD_LAT=1 and RD_LAT=3,
// both TIMEOUT=16) share stimulus through a select; a table of frames is
// applied and checked, followed by hand-written multi-cycle sequences.
module tb_npu_cfg_uart_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;
  logic        halted;

  logic        rx_ready_a, tx_valid_a, cfg_wr_en_a, cfg_rd_en_a, busy_a;
  logic [7:0]  tx_data_a, err_count_a;
  logic [15:0] cfg_addr_a;
  logic [31:0] cfg_wdata_a, cfg_rdata_a;
  logic        rx_ready_b, tx_valid_b, cfg_wr_en_b, cfg_rd_en_b, busy_b;
  logic [7:0]  tx_data_b, err_count_b;
  logic [15:0] cfg_addr_b;
  logic [31:0] cfg_wdata_b, cfg_rdata_b;

  logic        rx_valid_a, rx_valid_b;
  logic        rx_ready_m, tx_valid_m, cfg_wr_en_m, cfg_rd_en_m, busy_m;
  logic [7:0]  tx_data_m, err_count_m;
  logic [15:0] cfg_addr_m;
  logic [31:0] cfg_wdata_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rx_valid_a  = rx_valid && !sel;
  assign rx_valid_b  = rx_valid && sel;
  assign rx_ready_m  = sel ? rx_ready_b  : rx_ready_a;
  assign tx_valid_m  = sel ? tx_valid_b  : tx_valid_a;
  assign tx_data_m   = sel ? tx_data_b   : tx_data_a;
  assign cfg_wr_en_m = sel ? cfg_wr_en_b : cfg_wr_en_a;
  assign cfg_rd_en_m = sel ? cfg_rd_en_b : cfg_rd_en_a;
  assign cfg_addr_m  = sel ? cfg_addr_b  : cfg_addr_a;
  assign cfg_wdata_m = sel ? cfg_wdata_b : cfg_wdata_a;
  assign busy_m      = sel ? busy_b      : busy_a;
  assign err_count_m = sel ? err_count_b : err_count_a;

  npu_cfg_uart_bridge #(.RD_LAT(1), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid_a),
    .rx_ready(rx_ready_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready), .cfg_addr(cfg_addr_a), .cfg_wr_en(cfg_wr_en_a),
    .cfg_rd_en(cfg_rd_en_a), .cfg_wdata(cfg_wdata_a), .cfg_rdata(cfg_rdata_a),
    .halted(halted), .busy(busy_a), .err_count(err_count_a));

  npu_cfg_uart_bridge #(.RD_LAT(3), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid_b),
    .rx_ready(rx_ready_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready), .cfg_addr(cfg_addr_b), .cfg_wr_en(cfg_wr_en_b),
    .cfg_rd_en(cfg_rd_en_b), .cfg_wdata(cfg_wdata_b), .cfg_rdata(cfg_rdata_b),
    .halted(halted), .busy(busy_b), .err_count(err_count_b));

  // Config memory models: data valid only in the cycle RD_LAT after the strobe.
  function automatic logic [31:0] mem_val(input logic [15:0] a);
    return (a == 16'h0020) ? 32'h12345678 : {16'hC0DE, a};
  endfunction

  logic [3:0]  pipe_a = '0, pipe_b = '0;
  logic [15:0] raddr_a = '0, raddr_b = '0;
  always @(posedge clk) begin
    pipe_a <= {pipe_a[2:0], cfg_rd_en_a};
    pipe_b <= {pipe_b[2:0], cfg_rd_en_b};
    if (cfg_rd_en_a) raddr_a <= cfg_addr_a;
    if (cfg_rd_en_b) raddr_b <= cfg_addr_b;
  end
  assign cfg_rdata_a = pipe_a[0] ? mem_val(raddr_a) : 32'hBAD0BAD0;
  assign cfg_rdata_b = pipe_b[2] ? mem_val(raddr_b) : 32'hBAD0BAD0;

  // Bus monitors, sampled on the falling edge.
  logic [7:0]  txq[$];
  int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [15:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid_m && tx_ready) txq.push_back(tx_data_m);
      if (cfg_wr_en_m) begin
        wr_cnt     <= wr_cnt + 1;
        last_addr  <= cfg_addr_m;
        last_wdata <= cfg_wdata_m;
      end
      if (cfg_rd_en_m) begin
        rd_cnt    <= rd_cnt + 1;
        last_addr <= cfg_addr_m;
      end
      if (cfg_wr_en_m && cfg_rd_en_m) both_cnt <= both_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_ready_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept", 32'(rx_ready_m), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_m && n < 100);
    chk("busy_idle", 32'(busy_m), 32'd0);
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic            sel;
    logic            hlt;
    int              nb;
    logic [6:0][7:0] b;
    int              nt;
    logic [3:0][7:0] t;
    int              nwr;
    int              nrd;
    logic [15:0]     addr;
    logic [31:0]     wdata;
    logic [7:0]      err;
  } vec_t;

  vec_t v[8];

  initial begin
    int q0, wr0, rd0, n;

    v[0] = '{sel:0, hlt:0, nb:7, b:56'h57_00_10_DE_AD_BE_EF, nt:1, t:32'h4B000000,
             nwr:1, nrd:0, addr:16'h0010, wdata:32'hDEADBEEF, err:8'd0};
    v[1] = '{sel:0, hlt:0, nb:3, b:56'h52_00_20_00_00_00_00, nt:4, t:32'h12345678,
             nwr:0, nrd:1, addr:16'h0020, wdata:32'h0, err:8'd0};
    v[2] = '{sel:1, hlt:0, nb:3, b:56'h52_00_20_00_00_00_00, nt:4, t:32'h12345678,
             nwr:0, nrd:1, addr:16'h0020, wdata:32'h0, err:8'd0};
    v[3] = '{sel:1, hlt:0, nb:3, b:56'h52_12_34_00_00_00_00, nt:4, t:32'hC0DE1234,
             nwr:0, nrd:1, addr:16'h1234, wdata:32'h0, err:8'd0};
    v[4] = '{sel:0, hlt:0, nb:1, b:56'hA5_00_00_00_00_00_00, nt:1, t:32'h45000000,
             nwr:0, nrd:0, addr:16'h0, wdata:32'h0, err:8'd1};
    v[5] = '{sel:0, hlt:1, nb:1, b:56'h53_00_00_00_00_00_00, nt:1, t:32'h01000000,
             nwr:0, nrd:0, addr:16'h0, wdata:32'h0, err:8'd1};
    v[6] = '{sel:0, hlt:0, nb:1, b:56'h53_00_00_00_00_00_00, nt:1, t:32'h00000000,
             nwr:0, nrd:0, addr:16'h0, wdata:32'h0, err:8'd1};
    v[7] = '{sel:0, hlt:0, nb:7, b:56'h57_12_34_00_00_00_01, nt:1, t:32'h4B000000,
             nwr:1, nrd:0, addr:16'h1234, wdata:32'h00000001, err:8'd1};

    rst_n = 1'b0; sel = 1'b0; rx_data = '0; rx_valid = 1'b0;
    tx_ready = 1'b1; halted = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rx_ready", 32'(rx_ready_a), 32'd1);
    chk("rst_rx_ready_b", 32'(rx_ready_b), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid_a), 32'd0);
    chk("rst_tx_data", 32'(tx_data_a), 32'd0);
    chk("rst_strobes", {30'd0, cfg_wr_en_a, cfg_rd_en_a}, 32'd0);
    chk("rst_cfg_addr", 32'(cfg_addr_a), 32'd0);
    chk("rst_cfg_wdata", cfg_wdata_a, 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_err_count", 32'(err_count_a), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven frames with tx_ready held high
    for (int k = 0; k < 8; k++) begin
      sel = v[k].sel; halted = v[k].hlt; tx_ready = 1'b1;
      q0 = txq.size(); wr0 = wr_cnt; rd0 = rd_cnt;
      for (int i = 0; i < v[k].nb; i++) send_byte(v[k].b[6-i]);
      rx_valid = 1'b0;
      wait_idle();
      chk($sformatf("v%0d_ntx", k), 32'(txq.size() - q0), 32'(v[k].nt));
      for (int i = 0; i < v[k].nt; i++)
        if (q0 + i < txq.size())
          chk($sformatf("v%0d_tx%0d", k, i), 32'(txq[q0+i]), 32'(v[k].t[3-i]));
      chk($sformatf("v%0d_nwr", k), 32'(wr_cnt - wr0), 32'(v[k].nwr));
      chk($sformatf("v%0d_nrd", k), 32'(rd_cnt - rd0), 32'(v[k].nrd));
      if (v[k].nwr + v[k].nrd > 0)
        chk($sformatf("v%0d_addr", k), 32'(last_addr), 32'(v[k].addr));
      if (v[k].nwr > 0)
        chk($sformatf("v%0d_wdata", k), last_wdata, v[k].wdata);
      chk($sformatf("v%0d_err", k), 32'(err_count_m), 32'(v[k].err));
    end

    // Backpressure during a read response
    sel = 1'b0; tx_ready = 1'b0;
    q0 = txq.size();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
    rx_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid_m && n < 20);
    chk("bp_first_valid", 32'(tx_valid_m), 32'd1);
    chk("bp_first_byte", 32'(tx_data_m), 32'h12);
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(tx_data_m), 32'h34);
      chk("bp_hold_valid", 32'(tx_valid_m), 32'd1);
      chk("bp_rx_ready", 32'(rx_ready_m), 32'd0);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle();
    chk("bp_ntx", 32'(txq.size() - q0), 32'd4);
    chk("bp_bytes", (txq.size() - q0 == 4) ?
        {txq[q0], txq[q0+1], txq[q0+2], txq[q0+3]} : 32'hFFFFFFFF, 32'h12345678);

    // Timeout: 57 00 then stall; error response after 16 idle cycles
    q0 = txq.size(); wr0 = wr_cnt;
    send_byte(8'h57); send_byte(8'h00);
    rx_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid_m && n < 40);
    chk("to_latency", 32'(n), 32'd17);
    wait_idle();
    chk("to_ntx", 32'(txq.size() - q0), 32'd1);
    chk("to_byte", (txq.size() > q0) ? 32'(txq[q0]) : 32'hFFFF, 32'h45);
    chk("to_no_wr", 32'(wr_cnt - wr0), 32'd0);
    chk("to_err", 32'(err_count_m), 32'd2);

    // Byte arriving in the expiry cycle wins; frame then completes normally
    q0 = txq.size(); wr0 = wr_cnt;
    send_byte(8'h57); send_byte(8'h00);
    rx_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    send_byte(8'h10); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
    send_byte(8'hEF);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("lat_exec_wr", 32'(cfg_wr_en_m), 32'd1);
    chk("lat_exec_txv", 32'(tx_valid_m), 32'd0);
    chk("lat_exec_addr", 32'(cfg_addr_m), 32'h0010);
    chk("lat_exec_wdata", cfg_wdata_m, 32'hDEADBEEF);
    @(negedge clk);
    chk("lat_ack_valid", 32'(tx_valid_m), 32'd1);
    chk("lat_ack_byte", 32'(tx_data_m), 32'h4B);
    wait_idle();
    chk("win_ntx", 32'(txq.size() - q0), 32'd1);
    chk("win_nwr", 32'(wr_cnt - wr0), 32'd1);
    chk("win_err", 32'(err_count_m), 32'd2);

    // Reset in the DATA state of a write
    wr0 = wr_cnt;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'hDE);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_rx_ready", 32'(rx_ready_m), 32'd1);
    chk("mrst_busy", 32'(busy_m), 32'd0);
    chk("mrst_tx_valid", 32'(tx_valid_m), 32'd0);
    chk("mrst_cfg_addr", 32'(cfg_addr_m), 32'd0);
    chk("mrst_cfg_wdata", cfg_wdata_m, 32'd0);
    chk("mrst_err", 32'(err_count_m), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mrst_no_wr", 32'(wr_cnt - wr0), 32'd0);
    chk("mrst_idle", 32'(busy_m), 32'd0);
    @(posedge clk);
    #1;

    // err_count saturation
    for (int i = 0; i < 255; i++) send_byte(8'hA5);
    rx_valid = 1'b0;
    wait_idle();
    chk("sat_255", 32'(err_count_m), 32'hFF);
    send_byte(8'hA5);
    rx_valid = 1'b0;
    wait_idle();
    chk("sat_256", 32'(err_count_m), 32'hFF);
    chk("sat_last_byte", 32'(txq[txq.size()-1]), 32'h45);

    chk("no_dual_strobe", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
